// File: rtl/life_pkg.sv
// Shared command opcodes and sequencer state encoding for the Game-of-Life controller.
package life_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_RUN   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_STEP  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_PAUSE = OP_W'(4);
    localparam logic [OP_W-1:0] OP_CLEAR = OP_W'(5);

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_PACE   = 3'd5
    } life_state_e;

endpackage

// File: rtl/life_pace_timer.sv
// Loadable down-counter that stops at zero; times the settle window and the
// inter-generation pacing gap.
module life_pace_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_c_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/life_gen_ctrl.sv
// Game-of-Life sequencer: seeds the cell grid row by row, then steps, runs or
// pauses generations, counting them and halting on a target or a still board.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter  int unsigned ROWS   = 8,
    parameter  int unsigned COLS   = 8,
    parameter  int unsigned GEN_W  = 16,
    parameter  int unsigned SETTLE = 2,
    parameter  int unsigned PACE_W = 8,
    localparam int unsigned RW     = $clog2(ROWS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_c_o,
    input  logic [OP_W-1:0]   cmd_op_i,
    input  logic [GEN_W-1:0]  cmd_arg_i,
    input  logic [PACE_W-1:0] pace_i,
    input  logic              seed_valid_i,
    output logic              seed_ready_o,
    input  logic [COLS-1:0]   seed_row_i,
    output logic              grid_load_en_c_o,
    output logic [RW-1:0]     grid_load_idx_o,
    output logic [COLS-1:0]   grid_load_data_c_o,
    output logic              grid_clear_o,
    output logic              grid_step_o,
    input  logic              grid_changed_i,
    output logic              busy_o,
    output logic [GEN_W-1:0]  gen_count_o,
    output logic              stable_o,
    output logic              done_o
);

    localparam int unsigned SET_W = $clog2(SETTLE + 1);
    localparam int unsigned TMR_W = (PACE_W > SET_W) ? PACE_W : SET_W;

    life_state_e      state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [GEN_W-1:0] exec_q, exec_d;
    logic [GEN_W-1:0] target_q, target_d;
    logic             stable_q, stable_d;
    logic             pause_q, pause_d;
    logic             done_q, done_d;
    logic             step_q, clear_q, seed_ready_q, busy_q;
    logic             settle_load, pace_load, settle_zero, pace_zero;
    logic             cmd_fire, pause_fire, load_fire;

    // Outside IDLE only PAUSE is offered a ready, so other commands stall.
    assign cmd_ready_c_o = (state_q == ST_IDLE) || (cmd_op_i == OP_PAUSE);
    assign cmd_fire      = cmd_valid_i && cmd_ready_c_o;
    assign pause_fire    = cmd_fire && (cmd_op_i == OP_PAUSE);
    assign load_fire     = seed_valid_i && seed_ready_q && !rst_i;

    life_pace_timer #(.W(TMR_W)) u_settle_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (settle_load),
        .load_val_i (TMR_W'(SETTLE - 1)),
        .zero_c_o   (settle_zero)
    );

    life_pace_timer #(.W(TMR_W)) u_pace_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (pace_load),
        .load_val_i (TMR_W'(pace_i - PACE_W'(1))),
        .zero_c_o   (pace_zero)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        gen_d       = gen_q;
        exec_d      = exec_q;
        target_d    = target_q;
        stable_d    = stable_q;
        pause_d     = pause_q;
        done_d      = 1'b0;
        settle_load = 1'b0;
        pace_load   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op_i)
                        OP_LOAD: begin
                            state_d  = ST_LOAD;
                            row_d    = '0;
                            gen_d    = '0;
                            stable_d = 1'b0;
                        end
                        OP_CLEAR: state_d = ST_CLEAR;
                        OP_RUN: begin
                            state_d  = ST_STEP;
                            target_d = cmd_arg_i;
                            exec_d   = '0;
                            pause_d  = 1'b0;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            target_d = GEN_W'(1);
                            exec_d   = '0;
                            pause_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (load_fire) begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                gen_d    = '0;
                stable_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_STEP: begin
                if (pause_fire) pause_d = 1'b1;
                gen_d       = gen_q + GEN_W'(1);
                exec_d      = exec_q + GEN_W'(1);
                settle_load = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (pause_fire) pause_d = 1'b1;
                // Last settle cycle: grid_changed now reflects the new generation.
                if (settle_zero) begin
                    stable_d = !grid_changed_i;
                    if (pause_d || (target_q != '0 && exec_q == target_q) || !grid_changed_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (pace_i == '0) begin
                        state_d = ST_STEP;
                    end else begin
                        pace_load = 1'b1;
                        state_d   = ST_PACE;
                    end
                end
            end
            ST_PACE: begin
                if (pause_fire) pause_d = 1'b1;
                if (pace_zero) state_d = ST_STEP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            gen_q        <= '0;
            exec_q       <= '0;
            target_q     <= '0;
            stable_q     <= 1'b0;
            pause_q      <= 1'b0;
            done_q       <= 1'b0;
            step_q       <= 1'b0;
            clear_q      <= 1'b0;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            gen_q        <= gen_d;
            exec_q       <= exec_d;
            target_q     <= target_d;
            stable_q     <= stable_d;
            pause_q      <= pause_d;
            done_q       <= done_d;
            step_q       <= (state_d == ST_STEP);
            clear_q      <= (state_d == ST_CLEAR);
            seed_ready_q <= (state_d == ST_LOAD);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign seed_ready_o       = seed_ready_q;
    assign grid_load_en_c_o   = load_fire;
    assign grid_load_idx_o    = row_q;
    assign grid_load_data_c_o = seed_row_i;
    assign grid_clear_o       = clear_q;
    assign grid_step_o        = step_q;
    assign busy_o             = busy_q;
    assign gen_count_o        = gen_q;
    assign stable_o           = stable_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: a generation-level timing model predicts every grid
// pulse and done; a monitor matches what the sequencer emits against that queue.
module tb_life_gen_ctrl;
    import life_pkg::*;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned GEN_W  = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned PACE_W = 8;
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int GEN_MOD = 2 ** GEN_W;
    localparam int BIG     = 1 << 30;
    localparam int K_LOAD = 0, K_STEP = 1, K_CLEAR = 2, K_DONE = 3;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op = OP_NOP;
    logic [GEN_W-1:0]  cmd_arg = '0;
    logic [PACE_W-1:0] pace = '0;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [COLS-1:0]   seed_row = '0;
    logic              grid_load_en;
    logic [RW-1:0]     grid_load_idx;
    logic [COLS-1:0]   grid_load_data;
    logic              grid_clear;
    logic              grid_step;
    logic              grid_changed;
    logic              busy;
    logic [GEN_W-1:0]  gen_count;
    logic              stable;
    logic              done;

    exp_t sb[$];
    int   cyc = 0;
    int   tot_steps = 0;
    int   stop_abs = BIG;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_gen = 0;
    int   m_stable = 0;

    life_gen_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .SETTLE(SETTLE), .PACE_W(PACE_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_ready_c_o      (cmd_ready),
        .cmd_op_i           (cmd_op),
        .cmd_arg_i          (cmd_arg),
        .pace_i             (pace),
        .seed_valid_i       (seed_valid),
        .seed_ready_o       (seed_ready),
        .seed_row_i         (seed_row),
        .grid_load_en_c_o   (grid_load_en),
        .grid_load_idx_o    (grid_load_idx),
        .grid_load_data_c_o (grid_load_data),
        .grid_clear_o       (grid_clear),
        .grid_step_o        (grid_step),
        .grid_changed_i     (grid_changed),
        .busy_o             (busy),
        .gen_count_o        (gen_count),
        .stable_o           (stable),
        .done_o             (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in grid: keeps changing until the planned still generation.
    always @(posedge clk) if (grid_step) tot_steps <= tot_steps + 1;
    assign grid_changed = (tot_steps < stop_abs);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input int kind, input int a, input int b);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d a=%0d b=%0d at cycle %0d, nothing expected",
                     kind, a, b, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b) begin
                n_fail++;
                $display("FAIL event_k%0d: got kind %0d cyc %0d a=%0d b=%0d, expected kind %0d cyc %0d a=%0d b=%0d",
                         e.kind, kind, cyc, a, b, e.kind, e.cyc, e.a, e.b);
            end
        end
    endtask

    task automatic monitor_cycle();
        int pulses;
        if (!rst) begin
            pulses = int'(grid_step) + int'(grid_clear) + int'(grid_load_en);
            if (pulses != 0) check("pulse_exclusive", (pulses > 1) ? 1 : 0, 0);
            if (grid_load_en) sb_pop(K_LOAD, int'(grid_load_idx), int'(grid_load_data));
            if (grid_step)    sb_pop(K_STEP, 0, 0);
            if (grid_clear)   sb_pop(K_CLEAR, 0, 0);
            if (done)         sb_pop(K_DONE, int'(gen_count), int'(stable));
        end
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [GEN_W-1:0] arg, output int acc);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        acc       = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    // rst_row >= 0 asserts rst while that row is offered.
    task automatic do_load(input bit walk, input int rst_row);
        int c, d, gap;
        issue(OP_LOAD, '0, c);
        m_gen    = 0;
        m_stable = 0;
        for (int r = 0; r < ROWS; r++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            d = walk ? (1 << r) : int'($urandom_range(0, 255));
            seed_row   = COLS'(d);
            seed_valid = 1'b1;
            if (r == rst_row) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_blocks_load_en", int'(grid_load_en), 0);
                @(posedge clk); #1;
                rst = 1'b0;
                seed_valid = 1'b0;
                m_gen    = 0;
                m_stable = 0;
                @(negedge clk);
                check("rst_cmd_ready", int'(cmd_ready), 1);
                check("rst_busy", int'(busy), 0);
                check("rst_seed_ready", int'(seed_ready), 0);
                check("rst_gen_count", int'(gen_count), m_gen);
                check("rst_stable", int'(stable), m_stable);
                return;
            end
            sb.push_back('{K_LOAD, cyc, r, d});
            @(posedge clk); #1;
            seed_valid = 1'b0;
        end
        @(negedge clk);
        check("load_busy_drop", int'(busy), 0);
        check("load_seed_ready_drop", int'(seed_ready), 0);
    endtask

    task automatic do_clear();
        int c;
        issue(OP_CLEAR, '0, c);
        sb.push_back('{K_CLEAR, c + 1, 0, 0});
        m_gen    = 0;
        m_stable = 1;
        @(negedge clk);
        @(negedge clk);
        check("clear_gen_count", int'(gen_count), m_gen);
        check("clear_stable", int'(stable), m_stable);
        check("clear_busy", int'(busy), 0);
    endtask

    // Each generation costs 1 + SETTLE + pace cycles; the run ends at the first
    // of: target reached, still board, or the generation a PAUSE lands in.
    task automatic do_run(input logic [OP_W-1:0] op, input int t_arg, input int p,
                          input int stop_at, input int pause_off, input logic [OP_W-1:0] bad_op);
        int c, g, n, nt, np, pc;
        pace     = PACE_W'(p);
        stop_abs = tot_steps + stop_at;
        issue(op, GEN_W'(t_arg), c);
        g  = 1 + SETTLE + p;
        nt = (op == OP_STEP) ? 1 : ((t_arg == 0) ? BIG : t_arg);
        np = BIG;
        pc = c + 2 + pause_off;
        if (pause_off >= 0) begin
            np = 1;
            while (c + 1 + (np - 1) * g + SETTLE < pc) np++;
        end
        n = nt;
        if (stop_at < n) n = stop_at;
        if (np < n) n = np;
        for (int k = 1; k <= n; k++) sb.push_back('{K_STEP, c + 1 + (k - 1) * g, 0, 0});
        m_gen    = (m_gen + n) % GEN_MOD;
        m_stable = (n >= stop_at) ? 1 : 0;
        sb.push_back('{K_DONE, c + 1 + (n - 1) * g + 1 + SETTLE, m_gen, m_stable});
        cmd_valid = 1'b1;
        cmd_op    = bad_op;
        @(negedge clk);
        check("busy_cmd_ready_low", int'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        if (pause_off >= 0) begin
            while (cyc < pc) begin @(posedge clk); #1; end
            cmd_valid = 1'b1;
            cmd_op    = OP_PAUSE;
            @(negedge clk);
            check("pause_cmd_ready", int'(cmd_ready), 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            cmd_op    = OP_NOP;
        end
        wait_idle();
    endtask

    initial begin
        int sel, t, p, st, po;
        logic [OP_W-1:0] rop, bop;
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_seed_ready", int'(seed_ready), 0);
        check("reset_load_en", int'(grid_load_en), 0);
        check("reset_step", int'(grid_step), 0);
        check("reset_clear", int'(grid_clear), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_gen_count", int'(gen_count), 0);
        check("reset_stable", int'(stable), 0);
        check("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_load(1'b1, -1);
        do_run(OP_STEP, 0, 0, BIG, -1, OP_LOAD);
        do_run(OP_RUN, 5, 3, BIG, -1, OP_STEP);
        do_run(OP_RUN, 0, 2, 4, -1, OP_LOAD);
        do_run(OP_RUN, 0, 3, BIG, 3, OP_STEP);
        do_clear();
        do_run(OP_RUN, 0, 1, 1, -1, OP_STEP);
        do_load(1'b0, -1);
        do_run(OP_RUN, 255, 0, BIG, -1, OP_LOAD);
        do_run(OP_STEP, 0, 0, BIG, -1, OP_CLEAR);

        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 9) do_load(1'b0, -1);
            if (i % 10 == 4) do_clear();
            rop = ($urandom_range(0, 1) == 0) ? OP_RUN : OP_STEP;
            t   = int'($urandom_range(0, 6));
            p   = int'($urandom_range(0, 4));
            st  = ($urandom_range(0, 2) == 0) ? BIG : int'($urandom_range(1, 8));
            po  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            if (rop == OP_RUN && t == 0 && st == BIG && po < 0) st = int'($urandom_range(1, 8));
            sel = int'($urandom_range(0, 3));
            bop = (sel == 0) ? OP_LOAD : (sel == 1) ? OP_RUN : (sel == 2) ? OP_STEP : OP_CLEAR;
            do_run(rop, t, p, st, po, bop);
        end

        do_load(1'b0, 3);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
